// File: rtl/btn_debounce_rpt.sv
// Pushbutton conditioner: synchronizes raw buttons, debounces them on clk_k sample
// ticks and emits one-clk press / auto-repeat / release pulses per button.

module btn_debounce_lane #(
  parameter int STABLE_TICKS = 8,
  parameter int RPT_DELAY    = 1000,
  parameter int RPT_RATE     = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic s,
  output logic level,
  output logic press,
  output logic rpt,
  output logic rel
);
  localparam int CW   = $clog2(STABLE_TICKS + 1);
  localparam int RMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_TICKS - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'((RPT_DELAY > 0) ? RPT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RTE_LAST = RW'(RPT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} st_t;

  st_t           st_q, st_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rpt_q, rpt_d;
  logic          rel_q, rel_d;

  always_comb begin
    st_d    = st_q;
    dcnt_d  = dcnt_q;
    rcnt_d  = rcnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rpt_d   = 1'b0;
    rel_d   = 1'b0;
    if (tick) begin
      if (s == level_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == ST_LAST) begin
        level_d = ~level_q;
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + CW'(1);
      end

      // A level edge overrides any repeat due on the same tick.
      if (!level_q && level_d) begin
        press_d = 1'b1;
        rpt_d   = 1'b1;
        rcnt_d  = '0;
        st_d    = (RPT_DELAY == 0) ? HOLD : DELAY;
      end else if (level_q && !level_d) begin
        rel_d  = 1'b1;
        rcnt_d = '0;
        st_d   = IDLE;
      end else begin
        case (st_q)
          DELAY: begin
            if (rcnt_q == DLY_LAST) begin
              rpt_d  = 1'b1;
              rcnt_d = '0;
              st_d   = REPEAT;
            end else begin
              rcnt_d = rcnt_q + RW'(1);
            end
          end
          REPEAT: begin
            if (rcnt_q == RTE_LAST) begin
              rpt_d  = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + RW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= IDLE;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rpt_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rpt_q   <= rpt_d;
      rel_q   <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rpt   = rpt_q;
  assign rel   = rel_q;
endmodule

module btn_debounce_rpt #(
  parameter int N_BTN        = 4,
  parameter int STABLE_TICKS = 8,
  parameter int RPT_DELAY    = 1000,
  parameter int RPT_RATE     = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_k,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_rpt,
  output logic [N_BTN-1:0] btn_release
);
  logic             clk_k_q, clk_k_d;
  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic             tick;

  // clk_k already comes from a clk-domain register, so only edge detection is needed.
  assign tick = clk_k & ~clk_k_q;

  always_comb begin
    clk_k_d = clk_k;
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_k_q <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      clk_k_q <= clk_k_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    btn_debounce_lane #(
      .STABLE_TICKS (STABLE_TICKS),
      .RPT_DELAY    (RPT_DELAY),
      .RPT_RATE     (RPT_RATE)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .s     (sync2_q[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rpt   (btn_rpt[i]),
      .rel   (btn_release[i])
    );
  end
endmodule

// File: tb/tb_btn_debounce_rpt.sv
// Directed bench for btn_debounce_rpt: one instance with auto-repeat, one with it disabled.

module tb_btn_debounce_rpt;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_k = 1'b0;
  logic [3:0] btn_raw = 4'b1111;
  logic [3:0] raw0 = 4'b0000;
  logic [3:0] btn_level, btn_press, btn_rpt, btn_release;
  logic [3:0] lvl0, prs0, rpt0, rel0;

  int n_cmp = 0;
  int n_err = 0;
  int kdiv = 0;
  int n_press [4];
  int n_rpt [4];
  int n_rel [4];
  int n0_rpt = 0;
  int rst_bad = 0;

  btn_debounce_rpt #(.N_BTN(4), .STABLE_TICKS(4), .RPT_DELAY(10), .RPT_RATE(3)) dut (
    .clk(clk), .reset(reset), .clk_k(clk_k), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_rpt(btn_rpt), .btn_release(btn_release));

  btn_debounce_rpt #(.N_BTN(4), .STABLE_TICKS(4), .RPT_DELAY(0), .RPT_RATE(3)) dut0 (
    .clk(clk), .reset(reset), .clk_k(clk_k), .btn_raw(raw0),
    .btn_level(lvl0), .btn_press(prs0), .btn_rpt(rpt0), .btn_release(rel0));

  always #5 clk = ~clk;

  // clk_k toggles every 5 clk, changed mid-cycle
  always @(negedge clk) begin
    if (kdiv == 4) begin
      kdiv = 0;
      clk_k = ~clk_k;
    end else begin
      kdiv = kdiv + 1;
    end
  end

  // Pulse-cycle counters; a pulse wider than one clk is counted more than once.
  initial for (int i = 0; i < 4; i++) begin n_press[i] = 0; n_rpt[i] = 0; n_rel[i] = 0; end
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      n_press[i] += int'(btn_press[i]);
      n_rpt[i]   += int'(btn_rpt[i]);
      n_rel[i]   += int'(btn_release[i]);
    end
    n0_rpt += int'(rpt0[0]);
    if (reset && ({btn_level, btn_press, btn_rpt, btn_release, lvl0, prs0, rpt0, rel0} != '0))
      rst_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Return just after the clk edge on which the DUT consumes a sample tick.
  task automatic step();
    @(posedge clk_k);
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] obs, obs2, obs3, orel;
    int base_p, base_r;

    // Reset with all buttons held
    repeat (40) @(posedge clk);
    #1;
    chk("rst_outs", {btn_level, btn_press, btn_rpt, btn_release}, 32'h0);
    chk("rst_glitch", rst_bad, 0);
    @(negedge clk_k);
    @(posedge clk);
    #1 reset = 1'b0;
    steps(3);
    chk("rst_lvl_early", btn_level, 4'b0000);
    step();
    chk("rst_lvl", btn_level, 4'b1111);
    chk("rst_press", btn_press, 4'b1111);
    chk("rst_rpt", btn_rpt, 4'b1111);
    @(posedge clk);
    #1;
    chk("rst_press_w", btn_press, 4'b0000);
    btn_raw = 4'b0000;
    steps(4);
    chk("rst_rel", btn_release, 4'b1111);
    chk("rst_rel_rpt", btn_rpt, 4'b0000);
    chk("rst_lvl_off", btn_level, 4'b0000);
    for (int i = 0; i < 4; i++) chk("rst_rpt_cnt", n_rpt[i], 1);

    // Bounce rejection on bit 0
    base_p = n_press[0];
    btn_raw[0] = 1'b1;
    steps(3);
    btn_raw[0] = 1'b0;
    step();
    btn_raw[0] = 1'b1;
    steps(3);
    chk("bnc_lvl", btn_level, 4'b0000);
    chk("bnc_nopress", n_press[0] - base_p, 0);
    step();
    chk("bnc_lvl_on", btn_level, 4'b0001);
    chk("bnc_press", btn_press, 4'b0001);
    @(posedge clk);
    #1;
    chk("bnc_press_cnt", n_press[0] - base_p, 1);
    btn_raw[0] = 1'b0;
    steps(4);
    chk("bnc_rel", btn_release, 4'b0001);

    // Auto-repeat on bit 1, then release landing on a repeat tick
    btn_raw[1] = 1'b1;
    steps(4);
    chk("ar_press", btn_press, 4'b0010);
    chk("ar_rpt0", btn_rpt, 4'b0010);
    base_r = n_rpt[1];
    obs = '0;
    for (int k = 1; k <= 24; k++) begin
      step();
      obs[k] = btn_rpt[1];
    end
    chk("ar_sched", obs, 32'h0049_2400);
    btn_raw[1] = 1'b0;
    step();
    chk("ar_rpt25", btn_rpt, 4'b0010);
    steps(2);
    step();
    chk("rr_rel", btn_release, 4'b0010);
    chk("rr_norpt", btn_rpt, 4'b0000);
    chk("rr_lvl", btn_level, 4'b0000);
    steps(6);
    chk("ar_width_cnt", n_rpt[1] - base_r, 7);

    // Simultaneous bits 2 and 3; bit 2 released mid-schedule
    btn_raw = 4'b1100;
    steps(4);
    chk("sim_press", btn_press, 4'b1100);
    chk("sim_rpt", btn_rpt, 4'b1100);
    obs2 = '0; obs3 = '0; orel = '0;
    for (int k = 1; k <= 14; k++) begin
      step();
      obs2[k] = btn_rpt[2];
      obs3[k] = btn_rpt[3];
      orel[k] = btn_release[2];
      if (k == 5) btn_raw[2] = 1'b0;
    end
    chk("sim_rpt3", obs3, 32'h0000_2400);
    chk("sim_rpt2", obs2, 32'h0);
    chk("sim_rel2", orel, 32'h0000_0200);
    chk("sim_lvl", btn_level, 4'b1000);
    btn_raw = 4'b0000;
    steps(8);
    chk("sim_lvl_off", btn_level, 4'b0000);

    // Repeat disabled instance
    raw0 = 4'b0001;
    steps(4);
    chk("nr_press", prs0, 4'b0001);
    chk("nr_rpt", rpt0, 4'b0001);
    base_r = n0_rpt;
    steps(50);
    chk("nr_rpt_cnt", n0_rpt - base_r, 1);
    chk("nr_lvl", lvl0, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
